// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
// Channel-index width stays at least one bit so a single-channel build still has a cfg_chan port.
package clk_div_pkg;

  localparam int          CNT_W_DEF       = 32;
  localparam int unsigned DEFAULT_DIV_DEF = 32'd6_000_000;

  function automatic int chan_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: tick/clk_out registered, one cycle after the terminal count.
// A pending divisor is applied only at a period boundary, while paused, or on sync_clr; pend blocks further writes.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             xfer,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             pend,
  output logic             tick,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  logic [CNT_W-1:0] eff_div;
  logic             last;
  logic             commit;

  // ">=" rather than "==" so a divisor shrunk while paused ends the period on the next enabled edge.
  assign eff_div = (div_q == '0) ? CNT_W'(1) : div_q;
  assign last    = (cnt_q >= (eff_div - CNT_W'(1)));

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    tick_d = 1'b0;
    clk_d  = clk_q;
    commit = 1'b0;
    if (sync_clr) begin
      cnt_d  = '0;
      clk_d  = 1'b0;
      pend_d = 1'b0;
      if (pend_q) begin
        div_d = pdiv_q;
      end
      if (xfer) begin
        div_d  = cfg_div;
        pdiv_d = cfg_div;
      end
    end else begin
      if (en) begin
        if (last) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          clk_d  = ~clk_q;
          commit = pend_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        commit = pend_q;
      end
      if (commit) begin
        div_d  = pdiv_q;
        pend_d = 1'b0;
      end
      if (xfer) begin
        pdiv_d = cfg_div;
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= CNT_W'(DEFAULT_DIV);
      pdiv_q <= '0;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign pend    = pend_q;
  assign tick    = tick_q;
  assign clk_out = clk_q;

endmodule

// File: rtl/clk_div_multi.sv
// Bank of independent clock dividers with a shared valid/ready divisor-update port.
// cfg_ready is combinational from the addressed channel's pending flag; out-of-range channels accept and drop.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          CHANNELS    = 4,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int         CW          = chan_idx_w(CHANNELS)
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync_clr,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clk_out
);

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] xfer;

  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CW'(i)) begin
        cfg_ready = ~pend[i];
      end
    end
  end

  always_comb begin
    xfer = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      xfer[i] = cfg_valid & cfg_ready & (cfg_chan == CW'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (en[g]),
      .sync_clr(sync_clr),
      .xfer    (xfer[g]),
      .cfg_div (cfg_div),
      .pend    (pend[g]),
      .tick    (tick[g]),
      .clk_out (clk_out[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised and directed check of clk_div_multi against a per-channel period model.
module tb_clk_div_multi;

  localparam int NCH = 3;
  localparam int CW  = 8;

  logic            clk_in = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  en;
  logic            sync_clr;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [1:0]      cfg_chan;
  logic [CW-1:0]   cfg_div;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  clk_out;

  clk_div_multi #(
    .CHANNELS   (NCH),
    .CNT_W      (CW),
    .DEFAULT_DIV(4)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .tick     (tick),
    .clk_out  (clk_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Model: active/pending divisor, pending flag, enabled cycles elapsed in the current period, outputs.
  int m_d[NCH];
  int m_p[NCH];
  bit m_f[NCH];
  int m_e[NCH];
  bit m_clk[NCH];
  bit m_tick[NCH];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_d[i] = 4; m_p[i] = 0; m_f[i] = 0; m_e[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
    end
  endtask

  function automatic bit model_ready();
    if (int'(cfg_chan) >= NCH) return 1'b1;
    return !m_f[cfg_chan];
  endfunction

  task automatic model_step();
    bit xf, commit;
    for (int i = 0; i < NCH; i++) begin
      xf = cfg_valid && (int'(cfg_chan) == i) && !m_f[i];
      m_tick[i] = 0;
      if (sync_clr) begin
        m_e[i] = 0;
        m_clk[i] = 0;
        if (xf) m_d[i] = int'(cfg_div);
        else if (m_f[i]) m_d[i] = m_p[i];
        m_f[i] = 0;
      end else begin
        commit = 0;
        if (en[i]) begin
          if (m_e[i] + 1 >= eff(m_d[i])) begin
            m_tick[i] = 1;
            m_clk[i]  = !m_clk[i];
            m_e[i]    = 0;
            commit    = m_f[i];
          end else begin
            m_e[i]++;
          end
        end else begin
          commit = m_f[i];
        end
        if (commit) begin
          m_d[i] = m_p[i];
          m_f[i] = 0;
        end
        if (xf) begin
          m_p[i] = int'(cfg_div);
          m_f[i] = 1;
        end
      end
    end
  endtask

  // One clock: inputs are already driven (after a falling edge); ends at the next falling edge.
  task automatic cycle();
    logic [NCH-1:0] et, ec;
    #1;
    chk("cfg_ready", int'(cfg_ready), int'(model_ready()));
    @(posedge clk_in);
    model_step();
    #1;
    for (int i = 0; i < NCH; i++) begin
      et[i] = m_tick[i];
      ec[i] = m_clk[i];
    end
    chk("tick", int'(tick), int'(et));
    chk("clk_out", int'(clk_out), int'(ec));
    @(negedge clk_in);
  endtask

  task automatic wait_tick(input int ch, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      cycle();
      if (tick[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tick", int'(tick), 0);
    chk("async_rst_clk_out", int'(clk_out), 0);
    chk("async_rst_ready", int'(cfg_ready), 1);
    model_reset();
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    int n, mask0, c0_after4, c0_after8, ones, toggles, mask_a, mask_b;
    logic prev_clk, held_clk;

    rst_n = 1'b0; en = '0; sync_clr = 0; cfg_valid = 0; cfg_chan = 0; cfg_div = 0;
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    chk("reset_tick", int'(tick), 0);
    chk("reset_clk_out", int'(clk_out), 0);
    chk("reset_ready", int'(cfg_ready), 1);
    rst_n = 1'b1;

    // Default divisor 4: ticks on cycles 4, 8, 12.
    en = '1;
    mask0 = 0; c0_after4 = -1; c0_after8 = -1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (tick[0]) mask0 |= (1 << k);
      if (k == 4) c0_after4 = int'(clk_out[0]);
      if (k == 8) c0_after8 = int'(clk_out[0]);
    end
    chk("default_tick_cycles", mask0, (1 << 4) | (1 << 8) | (1 << 12));
    chk("clk_out_after_tick4", c0_after4, 1);
    chk("clk_out_after_tick8", c0_after8, 0);

    // Divisor change mid-period on ch1, then a refused second write.
    cycle();
    cfg_valid = 1; cfg_chan = 1; cfg_div = 3;
    #1 chk("ready_ch1_free", int'(cfg_ready), 1);
    cycle();
    cfg_div = 5;
    #1 chk("ready_ch1_pending", int'(cfg_ready), 0);
    cycle();
    cfg_valid = 0; cfg_chan = 0;
    #1 chk("ready_ch0_free", int'(cfg_ready), 1);
    wait_tick(1, 10, n);
    chk("ch1_old_period_end", n, 1);
    wait_tick(1, 10, n);
    chk("ch1_new_period_a", n, 3);
    wait_tick(1, 10, n);
    chk("ch1_new_period_b", n, 3);

    // Divisors 0 and 1 on ch2: continuous tick, toggle every cycle.
    for (int v = 0; v < 2; v++) begin
      cfg_valid = 1; cfg_chan = 2; cfg_div = CW'(v);
      cycle();
      cfg_valid = 0;
      wait_tick(2, 10, n);
      ones = 0; toggles = 0;
      for (int k = 0; k < 6; k++) begin
        prev_clk = clk_out[2];
        cycle();
        ones += int'(tick[2]);
        toggles += int'(clk_out[2] != prev_clk);
      end
      chk("ch2_tick_high", ones, 6);
      chk("ch2_toggles", toggles, 6);
    end

    // sync_clr with simultaneous ch0 transfer of divisor 2.
    sync_clr = 1; cfg_valid = 1; cfg_chan = 0; cfg_div = 2;
    cycle();
    chk("sync_clk_out", int'(clk_out), 0);
    chk("sync_tick", int'(tick), 0);
    sync_clr = 0; cfg_valid = 0;
    mask_a = 0; mask_b = 0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (tick[0]) mask_a |= (1 << k);
      if (tick[1]) mask_b |= (1 << k);
    end
    chk("sync_ch0_ticks", mask_a, 'h54);
    chk("sync_ch1_ticks", mask_b, 'h48);

    // Pause ch0 for 5 cycles: period of 2 stretches to 7.
    cycle();
    held_clk = clk_out[0];
    en[0] = 0;
    ones = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      ones += int'(tick[0]);
    end
    chk("pause_no_tick", ones, 0);
    chk("pause_clk_held", int'(clk_out[0]), int'(held_clk));
    en[0] = 1;
    wait_tick(0, 10, n);
    chk("pause_resume_edge", n, 1);

    // Pending write, then asynchronous reset mid-period.
    cfg_valid = 1; cfg_chan = 1; cfg_div = 7;
    cycle();
    cfg_valid = 0;
    #1 chk("ready_before_reset", int'(cfg_ready), 0);
    reset_pulse();

    // Full-scale divisor on ch1.
    cfg_valid = 1; cfg_chan = 1; cfg_div = 8'hFF;
    cycle();
    cfg_valid = 0;
    wait_tick(1, 10, n);
    wait_tick(1, 300, n);
    chk("max_div_period", n, 255);

    // Out-of-range channel: always ready, write dropped.
    cfg_valid = 1; cfg_chan = 3; cfg_div = 1;
    #1 chk("ready_out_of_range", int'(cfg_ready), 1);
    cycle();
    cfg_valid = 0;

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      en        = NCH'($urandom);
      sync_clr  = ($urandom_range(0, 99) < 2);
      cfg_valid = ($urandom_range(0, 99) < 30);
      cfg_chan  = 2'($urandom_range(0, 3));
      cfg_div   = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 40)) : CW'($urandom_range(0, 7));
      if ($urandom_range(0, 999) < 3) reset_pulse();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
